// File: rtl/attn_line_mac_ctrl_pkg.sv
// Shared types and defaults for the attention line-MAC PE sequencer.
package attn_mac_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        GAP0,
        FLUSH,
        DRAIN,
        CLEAR,
        DONE
    } state_e;

    localparam int unsigned DEF_LINE_LEN  = 64;
    localparam int unsigned DEF_NUM_LINES = 64;
    // Width of line/element indices (both limited to 2^12)
    localparam int unsigned IDX_W         = 12;
    // Drain counter needs one extra bit to reach LINE_LEN itself
    localparam int unsigned CNT_W         = IDX_W + 1;

endpackage

// File: rtl/attn_line_mac_ctrl_if.sv
// Control/strobe bundle between the sequencer and its RAMs / PE.
interface attn_line_mac_ctrl_if
    import attn_mac_pkg::*;
#(
    parameter int unsigned ADDR_W = 12
);
    logic              i_start;
    logic              i_hold;
    logic              o_busy;
    logic              o_done;
    logic              o_rd_en;
    logic [ADDR_W-1:0] o_attn_addr;
    logic [IDX_W-1:0]  o_spk_addr;
    logic              o_send_valid;
    logic              o_first_done;
    logic              o_finish_once;
    logic              o_final_rd;
    logic              o_result_valid;
    logic [IDX_W-1:0]  o_result_idx;

    // Sequencer side
    modport master (
        input  i_start, i_hold,
        output o_busy, o_done, o_rd_en, o_attn_addr, o_spk_addr, o_send_valid,
               o_first_done, o_finish_once, o_final_rd, o_result_valid, o_result_idx
    );

    // Job controller / PE side
    modport slave (
        output i_start, i_hold,
        input  o_busy, o_done, o_rd_en, o_attn_addr, o_spk_addr, o_send_valid,
               o_first_done, o_finish_once, o_final_rd, o_result_valid, o_result_idx
    );

endinterface

// File: rtl/attn_line_mac_ctrl_valid_delay_line.sv
// Valid + data delay pipe of DEPTH cycles; DEPTH=0 is a plain wire.
module valid_delay_line #(
    parameter int unsigned DEPTH = 1,
    parameter int unsigned W     = 1
) (
    input  logic         clk_i,
    input  logic         rst_i,
    input  logic         valid_i,
    input  logic [W-1:0] data_i,
    output logic         valid_o,
    output logic [W-1:0] data_o
);

    if (DEPTH == 0) begin : g_pass
        assign valid_o = valid_i;
        assign data_o  = data_i;
    end else begin : g_pipe
        logic [DEPTH-1:0] vld_q;
        logic [W-1:0]     dat_q [DEPTH];

        // Shift valid and payload together; reset flushes anything in flight
        always_ff @(posedge clk_i or posedge rst_i) begin
            if (rst_i) begin
                vld_q <= '0;
                for (int unsigned i = 0; i < DEPTH; i++) dat_q[i] <= '0;
            end else begin
                vld_q[0] <= valid_i;
                dat_q[0] <= data_i;
                for (int unsigned i = 1; i < DEPTH; i++) begin
                    vld_q[i] <= vld_q[i-1];
                    dat_q[i] <= dat_q[i-1];
                end
            end
        end

        assign valid_o = vld_q[DEPTH-1];
        assign data_o  = dat_q[DEPTH-1];
    end

endmodule

// File: rtl/attn_line_mac_ctrl.sv
// Sequencer for one attention x value line-MAC PE: issues line reads,
// marks first-line completion, drains the accumulated line, clears the PE.
module attn_line_mac_ctrl
    import attn_mac_pkg::*;
#(
    parameter int unsigned LINE_LEN    = DEF_LINE_LEN,
    parameter int unsigned NUM_LINES   = DEF_NUM_LINES,
    parameter int unsigned RD_LAT      = 1,
    parameter int unsigned FIFO_RD_LAT = 1,
    parameter int unsigned ADDR_W      = 12
) (
    input  logic                  s_clk,
    input  logic                  s_rst,
    attn_line_mac_ctrl_if.master  bus
);

    localparam logic [IDX_W-1:0] ELEM_LAST = IDX_W'(LINE_LEN - 1);
    localparam logic [IDX_W-1:0] LINE_LAST = IDX_W'(NUM_LINES - 1);
    localparam logic [CNT_W-1:0] DRAIN_END = CNT_W'(LINE_LEN);
    localparam logic [2:0]       FLUSH_END = 3'(RD_LAT);

    state_e              state_q, state_d;
    logic [IDX_W-1:0]    elem_q, elem_d;
    logic [IDX_W-1:0]    line_q, line_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [2:0]          flush_q, flush_d;
    logic [CNT_W-1:0]    drain_q, drain_d;
    logic                first_done_q;

    logic                rd_en;
    logic                final_rd;
    logic                last0;
    logic                send_valid;
    logic                send_last0;
    logic                res_valid;
    logic [IDX_W-1:0]    res_idx;

    // Next-state, counter updates and issue/drain strobes
    always_comb begin
        state_d  = state_q;
        elem_d   = elem_q;
        line_d   = line_q;
        addr_d   = addr_q;
        flush_d  = flush_q;
        drain_d  = drain_q;
        rd_en    = 1'b0;
        final_rd = 1'b0;
        last0    = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (bus.i_start) begin
                    state_d = ISSUE;
                    elem_d  = '0;
                    line_d  = '0;
                    addr_d  = '0;
                    flush_d = '0;
                    drain_d = '0;
                end
            end
            ISSUE: begin
                if (!bus.i_hold) begin
                    rd_en  = 1'b1;
                    addr_d = addr_q + 1'b1;
                    if (elem_q == ELEM_LAST) begin
                        elem_d = '0;
                        line_d = line_q + 1'b1;
                        if (line_q == LINE_LAST) begin
                            state_d = FLUSH;
                            flush_d = '0;
                        end else if (line_q == '0) begin
                            state_d = GAP0;
                            last0   = 1'b1;
                        end
                    end else begin
                        elem_d = elem_q + 1'b1;
                    end
                end
            end
            // Stay until the first-line pulse (tagged onto the last line-0
            // element) has left the send pipe, so no line-0 data is in flight
            GAP0: begin
                if (first_done_q) state_d = ISSUE;
            end
            FLUSH: begin
                if (flush_q == FLUSH_END) state_d = DRAIN;
                else                      flush_d = flush_q + 1'b1;
            end
            // Reads stop at LINE_LEN; the state is left only once the last
            // result word has come back out of the FIFO read pipe
            DRAIN: begin
                if (drain_q != DRAIN_END && !bus.i_hold) begin
                    final_rd = 1'b1;
                    drain_d  = drain_q + 1'b1;
                end
                if (res_valid && res_idx == ELEM_LAST) state_d = CLEAR;
            end
            CLEAR:   state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // State and counter registers
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) begin
            state_q <= IDLE;
            elem_q  <= '0;
            line_q  <= '0;
            addr_q  <= '0;
            flush_q <= '0;
            drain_q <= '0;
        end else begin
            state_q <= state_d;
            elem_q  <= elem_d;
            line_q  <= line_d;
            addr_q  <= addr_d;
            flush_q <= flush_d;
            drain_q <= drain_d;
        end
    end

    // First-line-done fires one cycle after the last line-0 element is sent
    always_ff @(posedge s_clk or posedge s_rst) begin
        if (s_rst) first_done_q <= 1'b0;
        else       first_done_q <= send_valid & send_last0;
    end

    valid_delay_line #(
        .DEPTH (RD_LAT),
        .W     (1)
    ) u_send_pipe (
        .clk_i   (s_clk),
        .rst_i   (s_rst),
        .valid_i (rd_en),
        .data_i  (last0),
        .valid_o (send_valid),
        .data_o  (send_last0)
    );

    valid_delay_line #(
        .DEPTH (FIFO_RD_LAT),
        .W     (IDX_W)
    ) u_res_pipe (
        .clk_i   (s_clk),
        .rst_i   (s_rst),
        .valid_i (final_rd),
        .data_i  (drain_q[IDX_W-1:0]),
        .valid_o (res_valid),
        .data_o  (res_idx)
    );

    assign bus.o_busy         = (state_q != IDLE);
    assign bus.o_done         = (state_q == DONE);
    assign bus.o_rd_en        = rd_en;
    assign bus.o_attn_addr    = addr_q;
    assign bus.o_spk_addr     = line_q;
    assign bus.o_send_valid   = send_valid;
    assign bus.o_first_done   = first_done_q;
    assign bus.o_finish_once  = (state_q == CLEAR);
    assign bus.o_final_rd     = final_rd;
    assign bus.o_result_valid = res_valid;
    assign bus.o_result_idx   = res_idx;

endmodule

// File: tb/tb_attn_line_mac_ctrl.sv
// Bench for attn_line_mac_ctrl: three configurations, RAM + PE model,
// scoreboard of expected result words per job.
`timescale 1ns/1ps
module tb_attn_line_mac_ctrl;

    localparam int LL [3] = '{4, 4, 4};
    localparam int NL [3] = '{3, 1, 3};
    localparam int RL [3] = '{1, 1, 3};
    localparam int FL [3] = '{1, 1, 2};

    typedef struct {
        int unsigned g;
        int unsigned idx;
        int unsigned val;
    } sb_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int unsigned total = 0;
    int unsigned bad   = 0;
    int unsigned starts [3] = '{0, 0, 0};
    int unsigned hold_x [3] = '{0, 0, 0};
    int unsigned attn_m [3][12];
    int unsigned spk_m  [3][3];
    sb_t         sbq [$];

    logic [2:0]  start = '0;
    logic [2:0]  hold  = '0;
    logic [2:0]  busy, done, rd_en, send_v, first_d, fin, final_rd, res_v;
    logic [11:0] attn_a [3];
    logic [11:0] spk_a  [3];
    logic [11:0] ridx   [3];

    attn_line_mac_ctrl_if #(.ADDR_W(4)) bus0 ();
    attn_line_mac_ctrl_if #(.ADDR_W(2)) bus1 ();
    attn_line_mac_ctrl_if #(.ADDR_W(4)) bus2 ();

    attn_line_mac_ctrl #(.LINE_LEN(4), .NUM_LINES(3), .RD_LAT(1), .FIFO_RD_LAT(1), .ADDR_W(4))
        dut0 (.s_clk(clk), .s_rst(rst), .bus(bus0));
    attn_line_mac_ctrl #(.LINE_LEN(4), .NUM_LINES(1), .RD_LAT(1), .FIFO_RD_LAT(1), .ADDR_W(2))
        dut1 (.s_clk(clk), .s_rst(rst), .bus(bus1));
    attn_line_mac_ctrl #(.LINE_LEN(4), .NUM_LINES(3), .RD_LAT(3), .FIFO_RD_LAT(2), .ADDR_W(4))
        dut2 (.s_clk(clk), .s_rst(rst), .bus(bus2));

    assign bus0.i_start = start[0];
    assign bus1.i_start = start[1];
    assign bus2.i_start = start[2];
    assign bus0.i_hold  = hold[0];
    assign bus1.i_hold  = hold[1];
    assign bus2.i_hold  = hold[2];

    assign busy     = {bus2.o_busy,         bus1.o_busy,         bus0.o_busy};
    assign done     = {bus2.o_done,         bus1.o_done,         bus0.o_done};
    assign rd_en    = {bus2.o_rd_en,        bus1.o_rd_en,        bus0.o_rd_en};
    assign send_v   = {bus2.o_send_valid,   bus1.o_send_valid,   bus0.o_send_valid};
    assign first_d  = {bus2.o_first_done,   bus1.o_first_done,   bus0.o_first_done};
    assign fin      = {bus2.o_finish_once,  bus1.o_finish_once,  bus0.o_finish_once};
    assign final_rd = {bus2.o_final_rd,     bus1.o_final_rd,     bus0.o_final_rd};
    assign res_v    = {bus2.o_result_valid, bus1.o_result_valid, bus0.o_result_valid};
    assign attn_a[0] = 12'(bus0.o_attn_addr);
    assign attn_a[1] = 12'(bus1.o_attn_addr);
    assign attn_a[2] = 12'(bus2.o_attn_addr);
    assign spk_a[0]  = bus0.o_spk_addr;
    assign spk_a[1]  = bus1.o_spk_addr;
    assign spk_a[2]  = bus2.o_spk_addr;
    assign ridx[0]   = bus0.o_result_idx;
    assign ridx[1]   = bus1.o_result_idx;
    assign ridx[2]   = bus2.o_result_idx;

    task automatic chk(input string tag, input int unsigned obs, input int unsigned exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // RAM model + PE model (line-accumulate FIFO) per instance
    for (genvar g = 0; g < 3; g++) begin : mon
        localparam int unsigned L   = LL[g];
        localparam int unsigned N   = NL[g];
        localparam int unsigned R   = RL[g];
        localparam int unsigned F   = FL[g];
        localparam int unsigned JOB = N*L + ((N > 1) ? R + 1 : 0) + R + 1 + L + F + 2;

        int unsigned rd_n, snd_n, fr_n, fd_n, bcnt;
        int unsigned last0_c, fd_c, lastrd_c, lastres_c, fin_c;
        bit          acc, pb;
        int unsigned psum [4];
        int unsigned rq_a [$];
        int unsigned rq_s [$];
        int unsigned oq_v [$];
        int unsigned oq_c [$];

        always @(negedge clk) begin
            int unsigned a, s, v, c;
            sb_t         e;
            if (busy[g] && !pb) starts[g]++;
            pb = busy[g];
            if (!busy[g]) begin
                rd_n = 0; snd_n = 0; fr_n = 0; fd_n = 0; bcnt = 0;
                last0_c = 0; fd_c = 0; lastrd_c = 0; lastres_c = 0; fin_c = 0;
                acc = 1'b0;
                rq_a.delete(); rq_s.delete(); oq_v.delete(); oq_c.delete();
            end else begin
                bcnt++;
                if (rd_en[g]) begin
                    chk($sformatf("u%0d.attn_addr", g), attn_a[g], rd_n);
                    chk($sformatf("u%0d.spk_addr", g), spk_a[g], rd_n / L);
                    if (N > 1 && rd_n == L) chk($sformatf("u%0d.resume_lag", g), cyc - fd_c, 1);
                    if (rd_n == L - 1) last0_c = cyc;
                    lastrd_c = cyc;
                    rq_a.push_back(attn_a[g]);
                    rq_s.push_back(spk_a[g]);
                    rd_n++;
                end
                if (send_v[g]) begin
                    chk($sformatf("u%0d.send_has_req", g), (rq_a.size() != 0), 1);
                    if (rq_a.size() != 0) begin
                        a = rq_a.pop_front();
                        s = rq_s.pop_front();
                        v = attn_m[g][a] * spk_m[g][s];
                        psum[snd_n % L] = (acc ? psum[snd_n % L] : 0) + v;
                    end
                    snd_n++;
                end
                if (first_d[g]) begin
                    fd_n++;
                    fd_c = cyc;
                    chk($sformatf("u%0d.first_done_lag", g), cyc - last0_c, R + 1);
                    chk($sformatf("u%0d.first_done_sent", g), snd_n, L);
                    acc = 1'b1;
                end
                if (final_rd[g]) begin
                    if (fr_n == 0) chk($sformatf("u%0d.drain_lag", g), cyc - lastrd_c, R + 2);
                    oq_v.push_back(psum[fr_n % L]);
                    oq_c.push_back(cyc);
                    fr_n++;
                end
                if (res_v[g]) begin
                    chk($sformatf("u%0d.res_has_src", g), (oq_v.size() != 0), 1);
                    chk($sformatf("u%0d.sb_nonempty", g), (sbq.size() != 0), 1);
                    if (oq_v.size() != 0 && sbq.size() != 0) begin
                        v = oq_v.pop_front();
                        c = oq_c.pop_front();
                        e = sbq.pop_front();
                        chk($sformatf("u%0d.res_lat", g), cyc - c, F);
                        chk($sformatf("u%0d.sb_inst", g), g, e.g);
                        chk($sformatf("u%0d.res_idx", g), ridx[g], e.idx);
                        chk($sformatf("u%0d.res_val", g), v, e.val);
                    end
                    lastres_c = cyc;
                end
                if (fin[g]) begin
                    chk($sformatf("u%0d.finish_lag", g), cyc - lastres_c, 1);
                    acc = 1'b0;
                    fin_c = cyc;
                end
                if (send_v[g] || final_rd[g] || fin[g])
                    chk($sformatf("u%0d.strobe_excl", g),
                        {30'd0, send_v[g] & final_rd[g], fin[g] & (send_v[g] | final_rd[g])}, 0);
                if (done[g]) begin
                    chk($sformatf("u%0d.done_lag", g), cyc - fin_c, 1);
                    chk($sformatf("u%0d.n_rd", g), rd_n, L * N);
                    chk($sformatf("u%0d.n_final", g), fr_n, L);
                    chk($sformatf("u%0d.n_first", g), fd_n, (N > 1) ? 1 : 0);
                    chk($sformatf("u%0d.job_len", g), bcnt, JOB + hold_x[g]);
                end
            end
        end
    end

    task automatic load(input int g, input bit rnd);
        for (int i = 0; i < 12; i++) attn_m[g][i] = rnd ? $urandom_range(0, 255) : 1;
        for (int i = 0; i < 3; i++)  spk_m[g][i]  = rnd ? $urandom_range(0, 1) : 1;
    endtask

    task automatic push_job(input int g);
        sb_t e;
        for (int el = 0; el < LL[g]; el++) begin
            e.g = g;
            e.idx = el;
            e.val = 0;
            for (int ln = 0; ln < NL[g]; ln++) e.val += attn_m[g][ln*LL[g] + el] * spk_m[g][ln];
            sbq.push_back(e);
        end
    endtask

    task automatic pulse_start(input int g);
        @(posedge clk); #1; start[g] = 1'b1;
        @(posedge clk); #1; start[g] = 1'b0;
    endtask

    task automatic wait_done(input int g);
        int k = 0;
        while (!done[g] && k < 300) begin @(posedge clk); #1; k++; end
        chk($sformatf("u%0d.done_seen", g), done[g], 1);
        @(posedge clk); #1;
        chk($sformatf("u%0d.sb_drained", g), sbq.size(), 0);
    endtask

    task automatic wait_final(input int g);
        int k = 0;
        while (!final_rd[g] && k < 300) begin @(posedge clk); #1; k++; end
        chk($sformatf("u%0d.drain_seen", g), final_rd[g], 1);
    endtask

    task automatic chk_zero(input int g, input string tag);
        chk($sformatf("u%0d.%s_strobes", g, tag),
            {24'd0, busy[g], done[g], rd_en[g], send_v[g], first_d[g], fin[g], final_rd[g], res_v[g]}, 0);
        chk($sformatf("u%0d.%s_buses", g, tag), {20'd0, attn_a[g] | spk_a[g] | ridx[g]}, 0);
    endtask

    initial begin
        int k;
        int unsigned s0;

        // Reset state
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        for (int g = 0; g < 3; g++) chk_zero(g, "reset");
        rst = 1'b0;

        // 1: 4x3, all ones -> every result is 3
        load(0, 1'b0);
        push_job(0);
        pulse_start(0);
        wait_done(0);

        // 2: single line, results are raw products
        load(1, 1'b1);
        spk_m[1][0] = 1;
        push_job(1);
        pulse_start(1);
        wait_done(1);

        // 3: hold 3 cycles mid-line 1, 2 cycles mid-drain
        load(0, 1'b1);
        push_job(0);
        hold_x[0] = 5;
        pulse_start(0);
        k = 0;
        while (!(rd_en[0] && attn_a[0] == 12'd5) && k < 100) begin @(posedge clk); #1; k++; end
        chk("u0.hold_point_seen", {31'd0, rd_en[0]}, 1);
        hold[0] = 1'b1;
        repeat (3) begin @(posedge clk); #1; end
        hold[0] = 1'b0;
        wait_final(0);
        @(posedge clk); #1;
        hold[0] = 1'b1;
        repeat (2) begin @(posedge clk); #1; end
        hold[0] = 1'b0;
        wait_done(0);
        hold_x[0] = 0;

        // 4: reset during drain, then a clean job
        load(0, 1'b1);
        push_job(0);
        pulse_start(0);
        wait_final(0);
        rst = 1'b1;
        #1;
        chk_zero(0, "abort");
        @(posedge clk); #1;
        rst = 1'b0;
        sbq.delete();
        push_job(0);
        pulse_start(0);
        wait_done(0);

        // 5: start held through a whole job, then back-to-back start
        load(0, 1'b1);
        s0 = starts[0];
        push_job(0);
        k = 0;
        do begin
            @(posedge clk); #1;
            start[0] = 1'b1;
            k++;
        end while (!done[0] && k < 300);
        chk("u0.held_start_done", done[0], 1);
        @(posedge clk); #1;
        chk("u0.one_job", starts[0] - s0, 1);
        push_job(0);
        @(posedge clk); #1;
        start[0] = 1'b0;
        wait_done(0);
        chk("u0.two_jobs", starts[0] - s0, 2);

        // 6: longer read latency, random data, two jobs
        for (int j = 0; j < 2; j++) begin
            load(2, 1'b1);
            push_job(2);
            pulse_start(2);
            wait_done(2);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
